load_store_queue: RTL and testbench
===================================

Name: load_store_queue

Overview:
- Parametrised in-order load/store queue between issue, the ROB, the CDB broadcast channels and the data-cache port.
- Holds up to DEPTH memory ops. Captures pending operands from CDB_N broadcast channels.
- Sends the head op to the cache only once it is safe: loads when the address is ready; stores when address and data are ready and the ROB has committed them.
- On flush, discards only speculative entries; committed stores are kept and drain to memory.

Parameters:
- DEPTH_LOG, 3, log2 of entry count (DEPTH = 2**DEPTH_LOG).
- ROB_ID_W, 4, ROB tag width.
- CDB_N, 2, number of CDB broadcast channels.
- XLEN, 32, data/address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- flush  in  1  branch mispredict; discard uncommitted entries
- iss_valid  in  1  enqueue request
- iss_is_store  in  1  1 = store, 0 = load
- iss_opcode  in  6  opcode passed to cache
- iss_rob_id  in  ROB_ID_W  owning ROB entry
- iss_addr_val  in  XLEN  address, or tag in low ROB_ID_W bits if not ready
- iss_addr_rdy  in  1  address valid
- iss_data_val  in  XLEN  store data, or tag if not ready
- iss_data_rdy  in  1  store data valid (ignored for loads)
- full  out  1  count == DEPTH
- cdb_valid  in  CDB_N  per-channel broadcast valid
- cdb_rob_id  in  CDB_N*ROB_ID_W  channel c in bits [c*ROB_ID_W +: ROB_ID_W]
- cdb_value  in  CDB_N*XLEN  channel c in bits [c*XLEN +: XLEN]
- commit_valid  in  1  ROB retiring an entry
- commit_rob_id  in  ROB_ID_W  retiring tag
- mem_req  out  1  cache request, held until mem_done
- mem_we  out  1  store request
- mem_opcode  out  6  head opcode
- mem_addr  out  XLEN  head address
- mem_wdata  out  XLEN  head store data
- mem_done  in  1  one-cycle completion pulse
- mem_rdata  in  XLEN  load data, valid with mem_done
- ld_valid  out  1  one-cycle load-result pulse
- ld_rob_id  out  ROB_ID_W  load tag
- ld_value  out  XLEN  load data

Behaviour:
- Storage and reset:
  - Circular buffer with head, tail and count of DEPTH_LOG+1 bits. Pointers wrap modulo DEPTH.
  - Per-entry fields: valid, is_store, opcode, rob_id, addr, addr_rdy, data, data_rdy, committed.
  - Reset: head = tail = count = 0, all valid and committed flags = 0, FSM = IDLE, mem_req = 0, mem_we = 0, ld_valid = 0. full is combinational, so 0 after reset.
- Enqueue:
  - iss_valid && !full && !flush writes the entry at tail and advances tail.
  - Loads store data_rdy = 1.
  - iss_valid while full is dropped. Upstream must not issue when full.
- Wakeup:
  - Each cycle, every valid entry with addr_rdy = 0 whose addr[ROB_ID_W-1:0] equals cdb_rob_id of a valid channel captures that channel's value and sets addr_rdy. Data is handled the same way.
  - If several channels match one operand, the lowest channel index wins.
- Commit:
  - commit_valid sets committed on the valid store entry whose rob_id matches.
  - A match on a load, or no match, is ignored. Commits are in order, so committed stores are always contiguous from head.
  - A committed-store counter tracks them.
- Memory FSM:
  - IDLE: head is valid and either (load && addr_rdy) or (store && addr_rdy && data_rdy && committed). Then drive mem_req = 1 with mem_we, mem_addr, mem_wdata and mem_opcode from head, and go to BUSY. The earliest request is the cycle after the head becomes eligible.
  - BUSY: hold mem_req and all mem_* outputs stable until mem_done.
  - On mem_done: drop mem_req, pop head, go to IDLE.
  - For a load, also pulse ld_valid for one cycle with ld_rob_id = head rob_id and ld_value = mem_rdata, registered, one cycle after mem_done.
  - A new request never starts in the same cycle as mem_done.
- Flush:
  - Tail is set to head + committed-store count, and count is set to the committed-store count. Valid flags of the dropped entries are cleared. Issue in the same cycle is dropped.
  - If a load is in BUSY during flush: keep mem_req asserted until mem_done, then discard the result (no ld_valid) and do not pop, since the entry is already gone.
  - A committed store in BUSY completes normally.
- Simultaneous enqueue and pop: count is unchanged. Enqueue of the entry that pops cannot happen.
- rdy = 0: no state changes. Outputs hold. A mem_done arriving while rdy = 0 is the cache's responsibility to avoid.

Optional Feature:
- LSQ_ISSUE_BYPASS_EN defined: at enqueue, an operand that is not ready is also compared against the same-cycle CDB channels. On a match, the entry is written ready with the broadcast value.
- Undefined: the operand is written unready. Upstream must itself forward a same-cycle broadcast, otherwise the entry never wakes.

Test Plan:
- Reset, then load to 0x100 rob 3 with address ready; mem_done with rdata 0xDEADBEEF -> mem_req rises next cycle with mem_we = 0; ld_valid pulses with rob 3 and value 0xDEADBEEF; count returns to 0.
- Store rob 5 with data tag 2 and address 0x40: no mem_req. Then CDB channel 1 carries rob 2 value 0x55 -> still no mem_req. Then commit rob 5 -> mem_req with mem_we = 1, mem_addr 0x40, mem_wdata 0x55.
- Enqueue 8 loads with addresses unready -> full = 1; a 9th iss_valid is dropped and count stays 8.
- Stores rob 1 and 2 committed, then load rob 3 and store rob 4 uncommitted; flush -> count = 2, both stores drain, ld_valid never asserts.
- Load in BUSY when flush arrives -> mem_req held until mem_done, no ld_valid, FSM returns to IDLE with count 0.
- CDB channels 0 and 1 both broadcast rob 7, with values 0x11 and 0x22, to a waiting entry -> the entry captures 0x11.

Source files
------------

// File: rtl/load_store_queue.sv
// In-order load/store queue: CDB operand wakeup, ROB commit tracking, single-outstanding cache port.
// Optional: define LSQ_ISSUE_BYPASS_EN to capture same-cycle CDB broadcasts at enqueue.
module load_store_queue #(
    parameter int DEPTH_LOG = 3,
    parameter int ROB_ID_W  = 4,
    parameter int CDB_N     = 2,
    parameter int XLEN      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      iss_valid,
    input  logic                      iss_is_store,
    input  logic [5:0]                iss_opcode,
    input  logic [ROB_ID_W-1:0]       iss_rob_id,
    input  logic [XLEN-1:0]           iss_addr_val,
    input  logic                      iss_addr_rdy,
    input  logic [XLEN-1:0]           iss_data_val,
    input  logic                      iss_data_rdy,
    output logic                      full,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [CDB_N*XLEN-1:0]     cdb_value,
    input  logic                      commit_valid,
    input  logic [ROB_ID_W-1:0]       commit_rob_id,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [5:0]                mem_opcode,
    output logic [XLEN-1:0]           mem_addr,
    output logic [XLEN-1:0]           mem_wdata,
    input  logic                      mem_done,
    input  logic [XLEN-1:0]           mem_rdata,
    output logic                      ld_valid,
    output logic [ROB_ID_W-1:0]       ld_rob_id,
    output logic [XLEN-1:0]           ld_value
);

    localparam int DEPTH = 2 ** DEPTH_LOG;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic [DEPTH_LOG-1:0] head, tail, head_nxt;
    logic [DEPTH_LOG:0]   count, cst_cnt, cst_nxt;

    logic                e_valid     [DEPTH];
    logic                e_store     [DEPTH];
    logic [5:0]          e_opcode    [DEPTH];
    logic [ROB_ID_W-1:0] e_rob       [DEPTH];
    logic [XLEN-1:0]     e_addr      [DEPTH];
    logic                e_addr_rdy  [DEPTH];
    logic [XLEN-1:0]     e_data      [DEPTH];
    logic                e_data_rdy  [DEPTH];
    logic                e_committed [DEPTH];

    logic                addr_hit    [DEPTH];
    logic [XLEN-1:0]     addr_cap    [DEPTH];
    logic                data_hit    [DEPTH];
    logic [XLEN-1:0]     data_cap    [DEPTH];
    logic                commit_set  [DEPTH];
    logic                commit_any;

    logic                iss_addr_hit, iss_data_hit;
    logic [XLEN-1:0]     iss_addr_cap, iss_data_cap;

    // Request latched at issue: the head entry may be flushed and overwritten while BUSY.
    logic                req_we;
    logic [5:0]          req_opcode;
    logic [ROB_ID_W-1:0] req_rob;
    logic [XLEN-1:0]     req_addr, req_wdata;
    logic                killed;

    logic busy, kill_now, done_ok, pop, pop_store, enq, head_ok, start;

    assign full      = (count == (DEPTH_LOG+1)'(DEPTH));
    assign busy      = (state == BUSY);
    assign kill_now  = killed || (flush && !req_we);
    assign done_ok   = busy && mem_done;
    assign pop       = done_ok && !kill_now;
    assign pop_store = pop && req_we;
    assign enq       = iss_valid && !full && !flush;
    assign head_nxt  = pop ? head + 1'b1 : head;
    assign cst_nxt   = cst_cnt + (DEPTH_LOG+1)'(commit_any) - (DEPTH_LOG+1)'(pop_store);
    assign head_ok   = e_valid[head] && e_addr_rdy[head] &&
                       (!e_store[head] || (e_data_rdy[head] && e_committed[head]));
    assign start     = !busy && head_ok && !flush;

    always_comb begin
        commit_any = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_hit[i]   = 1'b0;
            addr_cap[i]   = '0;
            data_hit[i]   = 1'b0;
            data_cap[i]   = '0;
            commit_set[i] = commit_valid && e_valid[i] && e_store[i] && !e_committed[i] &&
                            (e_rob[i] == commit_rob_id);
            commit_any    = commit_any | commit_set[i];
            for (int unsigned c = 0; c < CDB_N; c++) begin
                if (!addr_hit[i] && cdb_valid[c] &&
                    cdb_rob_id[c*ROB_ID_W +: ROB_ID_W] == e_addr[i][ROB_ID_W-1:0]) begin
                    addr_hit[i] = 1'b1;
                    addr_cap[i] = cdb_value[c*XLEN +: XLEN];
                end
                if (!data_hit[i] && cdb_valid[c] &&
                    cdb_rob_id[c*ROB_ID_W +: ROB_ID_W] == e_data[i][ROB_ID_W-1:0]) begin
                    data_hit[i] = 1'b1;
                    data_cap[i] = cdb_value[c*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef LSQ_ISSUE_BYPASS_EN
    always_comb begin
        iss_addr_hit = 1'b0;
        iss_addr_cap = '0;
        iss_data_hit = 1'b0;
        iss_data_cap = '0;
        for (int unsigned c = 0; c < CDB_N; c++) begin
            if (!iss_addr_hit && cdb_valid[c] &&
                cdb_rob_id[c*ROB_ID_W +: ROB_ID_W] == iss_addr_val[ROB_ID_W-1:0]) begin
                iss_addr_hit = 1'b1;
                iss_addr_cap = cdb_value[c*XLEN +: XLEN];
            end
            if (!iss_data_hit && cdb_valid[c] &&
                cdb_rob_id[c*ROB_ID_W +: ROB_ID_W] == iss_data_val[ROB_ID_W-1:0]) begin
                iss_data_hit = 1'b1;
                iss_data_cap = cdb_value[c*XLEN +: XLEN];
            end
        end
    end
`else
    assign iss_addr_hit = 1'b0;
    assign iss_addr_cap = '0;
    assign iss_data_hit = 1'b0;
    assign iss_data_cap = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst)      state <= IDLE;
        else if (rdy) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)    state_nxt = BUSY;
            BUSY: if (mem_done) state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req    = busy;
        mem_we     = busy && req_we;
        mem_opcode = req_opcode;
        mem_addr   = req_addr;
        mem_wdata  = req_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            cst_cnt    <= '0;
            killed     <= 1'b0;
            req_we     <= 1'b0;
            req_opcode <= '0;
            req_rob    <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
            ld_valid   <= 1'b0;
            ld_rob_id  <= '0;
            ld_value   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_valid[i]     <= 1'b0;
                e_committed[i] <= 1'b0;
            end
        end else if (rdy) begin
            head    <= head_nxt;
            cst_cnt <= cst_nxt;
            // Committed stores sit contiguously from head, so they are exactly what flush keeps.
            if (flush) begin
                count <= cst_nxt;
                tail  <= head_nxt + cst_nxt[DEPTH_LOG-1:0];
            end else begin
                count <= count + (DEPTH_LOG+1)'(enq) - (DEPTH_LOG+1)'(pop);
                tail  <= tail + DEPTH_LOG'(enq);
            end

            if (start) begin
                req_we     <= e_store[head];
                req_opcode <= e_opcode[head];
                req_rob    <= e_rob[head];
                req_addr   <= e_addr[head];
                req_wdata  <= e_data[head];
            end

            if (done_ok)                      killed <= 1'b0;
            else if (busy && flush && !req_we) killed <= 1'b1;

            ld_valid <= done_ok && !req_we && !kill_now;
            if (done_ok && !req_we && !kill_now) begin
                ld_rob_id <= req_rob;
                ld_value  <= mem_rdata;
            end

            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (enq && tail == DEPTH_LOG'(i)) begin
                    e_valid[i]     <= 1'b1;
                    e_store[i]     <= iss_is_store;
                    e_opcode[i]    <= iss_opcode;
                    e_rob[i]       <= iss_rob_id;
                    e_addr[i]      <= (iss_addr_rdy || !iss_addr_hit) ? iss_addr_val : iss_addr_cap;
                    e_addr_rdy[i]  <= iss_addr_rdy || iss_addr_hit;
                    e_data[i]      <= (iss_data_rdy || !iss_data_hit) ? iss_data_val : iss_data_cap;
                    e_data_rdy[i]  <= !iss_is_store || iss_data_rdy || iss_data_hit;
                    e_committed[i] <= 1'b0;
                end else begin
                    if (e_valid[i] && !e_addr_rdy[i] && addr_hit[i]) begin
                        e_addr[i]     <= addr_cap[i];
                        e_addr_rdy[i] <= 1'b1;
                    end
                    if (e_valid[i] && !e_data_rdy[i] && data_hit[i]) begin
                        e_data[i]     <= data_cap[i];
                        e_data_rdy[i] <= 1'b1;
                    end
                    if (commit_set[i]) e_committed[i] <= 1'b1;
                end
                if (flush && !(e_committed[i] || commit_set[i])) e_valid[i] <= 1'b0;
                if (pop && head == DEPTH_LOG'(i)) begin
                    e_valid[i]     <= 1'b0;
                    e_committed[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue: one task per scenario, hand-computed expectations.
module tb_load_store_queue;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        iss_valid, iss_is_store;
    logic [5:0]  iss_opcode;
    logic [3:0]  iss_rob_id;
    logic [31:0] iss_addr_val, iss_data_val;
    logic        iss_addr_rdy, iss_data_rdy;
    logic        full;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_id;
    logic [63:0] cdb_value;
    logic        commit_valid;
    logic [3:0]  commit_rob_id;
    logic        mem_req, mem_we;
    logic [5:0]  mem_opcode;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [3:0]  ld_rob_id;
    logic [31:0] ld_value;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    load_store_queue #(.DEPTH_LOG(3), .ROB_ID_W(4), .CDB_N(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .iss_valid(iss_valid), .iss_is_store(iss_is_store), .iss_opcode(iss_opcode),
        .iss_rob_id(iss_rob_id), .iss_addr_val(iss_addr_val), .iss_addr_rdy(iss_addr_rdy),
        .iss_data_val(iss_data_val), .iss_data_rdy(iss_data_rdy), .full(full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .mem_req(mem_req), .mem_we(mem_we), .mem_opcode(mem_opcode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_rob_id(ld_rob_id), .ld_value(ld_value)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; iss_valid = 0; iss_is_store = 0; iss_opcode = '0; iss_rob_id = '0;
        iss_addr_val = '0; iss_addr_rdy = 0; iss_data_val = '0; iss_data_rdy = 0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
        commit_valid = 0; commit_rob_id = '0; mem_done = 0; mem_rdata = '0;
    endtask

    task automatic issue(input logic st, input logic [3:0] rob, input logic [31:0] a,
                         input logic ar, input logic [31:0] d, input logic dr);
        iss_valid = 1; iss_is_store = st; iss_opcode = st ? 6'h23 : 6'h03; iss_rob_id = rob;
        iss_addr_val = a; iss_addr_rdy = ar; iss_data_val = d; iss_data_rdy = dr;
        tick();
        iss_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); rdy = 1; rst = 1;
        tick(); tick();
        rst = 0;
        total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else passed++;
        total++; if (ld_valid !== 1'b0) $display("FAIL reset_ld_valid: got %b want 0", ld_valid); else passed++;
        total++; if (dut.count !== 4'd0) $display("FAIL reset_count: got %0d want 0", dut.count); else passed++;
    endtask

    task automatic test_load();
        issue(1'b0, 4'd3, 32'h100, 1'b1, 32'h0, 1'b0);
        total++; if (mem_req !== 1'b0) $display("FAIL load_no_req_same_cycle: got %b want 0", mem_req); else passed++;
        tick();
        total++; if (mem_req !== 1'b1) $display("FAIL load_req: got %b want 1", mem_req); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL load_we: got %b want 0", mem_we); else passed++;
        total++; if (mem_addr !== 32'h100) $display("FAIL load_addr: got %h want 100", mem_addr); else passed++;
        tick();
        total++; if (mem_req !== 1'b1) $display("FAIL load_req_held: got %b want 1", mem_req); else passed++;
        mem_done = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_done = 0;
        total++; if (mem_req !== 1'b0) $display("FAIL load_req_drop: got %b want 0", mem_req); else passed++;
        total++; if (ld_valid !== 1'b1) $display("FAIL load_ld_valid: got %b want 1", ld_valid); else passed++;
        total++; if (ld_rob_id !== 4'd3) $display("FAIL load_ld_rob: got %0d want 3", ld_rob_id); else passed++;
        total++; if (ld_value !== 32'hDEADBEEF) $display("FAIL load_ld_value: got %h want deadbeef", ld_value); else passed++;
        total++; if (dut.count !== 4'd0) $display("FAIL load_count: got %0d want 0", dut.count); else passed++;
        tick();
        total++; if (ld_valid !== 1'b0) $display("FAIL load_ld_pulse: got %b want 0", ld_valid); else passed++;
    endtask

    task automatic test_store_commit();
        issue(1'b1, 4'd5, 32'h40, 1'b1, 32'd2, 1'b0);
        tick();
        total++; if (mem_req !== 1'b0) $display("FAIL store_wait_data: got %b want 0", mem_req); else passed++;
        cdb_valid = 2'b10; cdb_rob_id = {4'd2, 4'd0}; cdb_value = {32'h55, 32'h0};
        tick();
        cdb_valid = '0;
        tick();
        total++; if (mem_req !== 1'b0) $display("FAIL store_wait_commit: got %b want 0", mem_req); else passed++;
        commit_valid = 1; commit_rob_id = 4'd5;
        tick();
        commit_valid = 0;
        total++; if (mem_req !== 1'b0) $display("FAIL store_req_latency: got %b want 0", mem_req); else passed++;
        tick();
        total++; if (mem_req !== 1'b1) $display("FAIL store_req: got %b want 1", mem_req); else passed++;
        total++; if (mem_we !== 1'b1) $display("FAIL store_we: got %b want 1", mem_we); else passed++;
        total++; if (mem_addr !== 32'h40) $display("FAIL store_addr: got %h want 40", mem_addr); else passed++;
        total++; if (mem_wdata !== 32'h55) $display("FAIL store_wdata: got %h want 55", mem_wdata); else passed++;
        mem_done = 1;
        tick();
        mem_done = 0;
        total++; if (ld_valid !== 1'b0) $display("FAIL store_no_ld: got %b want 0", ld_valid); else passed++;
        total++; if (dut.count !== 4'd0) $display("FAIL store_count: got %0d want 0", dut.count); else passed++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) issue(1'b0, 4'(i), 32'hF, 1'b0, 32'h0, 1'b0);
        total++; if (full !== 1'b1) $display("FAIL full_flag: got %b want 1", full); else passed++;
        issue(1'b0, 4'd9, 32'h300, 1'b1, 32'h0, 1'b0);
        total++; if (dut.count !== 4'd8) $display("FAIL full_drop: got %0d want 8", dut.count); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL full_no_req: got %b want 0", mem_req); else passed++;
        flush = 1;
        tick();
        flush = 0;
        total++; if (dut.count !== 4'd0) $display("FAIL full_flush_count: got %0d want 0", dut.count); else passed++;
        total++; if (full !== 1'b0) $display("FAIL full_after_flush: got %b want 0", full); else passed++;
        tick();
        total++; if (mem_req !== 1'b0) $display("FAIL full_flushed_no_req: got %b want 0", mem_req); else passed++;
    endtask

    task automatic test_flush_stores();
        logic [31:0] seen_addr [2];
        logic [31:0] seen_data [2];
        int done_cnt = 0;
        logic saw_ld = 0;
        issue(1'b1, 4'd1, 32'h80, 1'b1, 32'hA1, 1'b1);
        issue(1'b1, 4'd2, 32'h84, 1'b1, 32'hA2, 1'b1);
        issue(1'b0, 4'd3, 32'h88, 1'b1, 32'h0,  1'b0);
        issue(1'b1, 4'd4, 32'h8C, 1'b1, 32'hA4, 1'b1);
        commit_valid = 1; commit_rob_id = 4'd1; tick();
        commit_rob_id = 4'd2; tick();
        commit_valid = 0;
        flush = 1; tick(); flush = 0;
        total++; if (dut.count !== 4'd2) $display("FAIL fstore_count: got %0d want 2", dut.count); else passed++;
        for (int cyc = 0; cyc < 30 && done_cnt < 2; cyc++) begin
            if (mem_req && !mem_done) begin
                seen_addr[done_cnt] = mem_addr;
                seen_data[done_cnt] = mem_wdata;
                done_cnt++;
                mem_done = 1;
            end else mem_done = 0;
            tick();
            if (ld_valid) saw_ld = 1;
        end
        mem_done = 0;
        tick(); tick();
        if (ld_valid) saw_ld = 1;
        total++; if (done_cnt !== 2) $display("FAIL fstore_drained: got %0d want 2", done_cnt); else passed++;
        if (done_cnt == 2) begin
            total++; if (seen_addr[0] !== 32'h80 || seen_data[0] !== 32'hA1)
                $display("FAIL fstore_first: got %h/%h want 80/a1", seen_addr[0], seen_data[0]); else passed++;
            total++; if (seen_addr[1] !== 32'h84 || seen_data[1] !== 32'hA2)
                $display("FAIL fstore_second: got %h/%h want 84/a2", seen_addr[1], seen_data[1]); else passed++;
        end
        total++; if (saw_ld !== 1'b0) $display("FAIL fstore_no_ld: got %b want 0", saw_ld); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL fstore_idle: got %b want 0", mem_req); else passed++;
        total++; if (dut.count !== 4'd0) $display("FAIL fstore_empty: got %0d want 0", dut.count); else passed++;
    endtask

    task automatic test_flush_busy_load();
        issue(1'b0, 4'd6, 32'h200, 1'b1, 32'h0, 1'b0);
        tick();
        total++; if (mem_req !== 1'b1) $display("FAIL fload_req: got %b want 1", mem_req); else passed++;
        flush = 1; tick(); flush = 0;
        total++; if (mem_req !== 1'b1) $display("FAIL fload_req_held: got %b want 1", mem_req); else passed++;
        total++; if (mem_addr !== 32'h200) $display("FAIL fload_addr_stable: got %h want 200", mem_addr); else passed++;
        total++; if (dut.count !== 4'd0) $display("FAIL fload_count: got %0d want 0", dut.count); else passed++;
        mem_done = 1; mem_rdata = 32'h1234;
        tick();
        mem_done = 0;
        total++; if (mem_req !== 1'b0) $display("FAIL fload_req_drop: got %b want 0", mem_req); else passed++;
        total++; if (ld_valid !== 1'b0) $display("FAIL fload_no_ld: got %b want 0", ld_valid); else passed++;
        tick();
        total++; if (mem_req !== 1'b0) $display("FAIL fload_stay_idle: got %b want 0", mem_req); else passed++;
        total++; if (dut.count !== 4'd0) $display("FAIL fload_count_end: got %0d want 0", dut.count); else passed++;
    endtask

    task automatic test_cdb_priority();
        issue(1'b0, 4'd8, 32'd7, 1'b0, 32'h0, 1'b0);
        tick();
        total++; if (mem_req !== 1'b0) $display("FAIL cdb_wait: got %b want 0", mem_req); else passed++;
        cdb_valid = 2'b11; cdb_rob_id = {4'd7, 4'd7}; cdb_value = {32'h22, 32'h11};
        tick();
        cdb_valid = '0;
        tick();
        total++; if (mem_req !== 1'b1) $display("FAIL cdb_req: got %b want 1", mem_req); else passed++;
        total++; if (mem_addr !== 32'h11) $display("FAIL cdb_low_channel_wins: got %h want 11", mem_addr); else passed++;
        mem_done = 1; mem_rdata = 32'h77;
        tick();
        mem_done = 0;
        total++; if (ld_valid !== 1'b1 || ld_rob_id !== 4'd8 || ld_value !== 32'h77)
            $display("FAIL cdb_ld: got %b/%0d/%h want 1/8/77", ld_valid, ld_rob_id, ld_value); else passed++;
    endtask

    task automatic test_rdy_freeze();
        tick();
        rdy = 0;
        issue(1'b0, 4'd9, 32'h400, 1'b1, 32'h0, 1'b0);
        total++; if (dut.count !== 4'd0) $display("FAIL rdy_no_enq: got %0d want 0", dut.count); else passed++;
        rdy = 1;
        issue(1'b0, 4'd9, 32'h400, 1'b1, 32'h0, 1'b0);
        total++; if (dut.count !== 4'd1) $display("FAIL rdy_enq: got %0d want 1", dut.count); else passed++;
        rdy = 0; tick();
        total++; if (mem_req !== 1'b0) $display("FAIL rdy_frozen_fsm: got %b want 0", mem_req); else passed++;
        rdy = 1; tick();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h400)
            $display("FAIL rdy_resume: got %b/%h want 1/400", mem_req, mem_addr); else passed++;
        mem_done = 1; mem_rdata = 32'h9;
        tick();
        mem_done = 0;
        total++; if (ld_valid !== 1'b1 || ld_value !== 32'h9)
            $display("FAIL rdy_ld: got %b/%h want 1/9", ld_valid, ld_value); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_store_commit();
        test_full();
        test_flush_stores();
        test_flush_busy_load();
        test_cdb_priority();
        test_rdy_freeze();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
